lift_ctrl: RTL and testbench
============================

Name: lift_ctrl

Overview:
Two-floor lift movement controller (ground/top).
- Sits directly downstream of the per-floor request latches.
- Consumes their request flags (req_g, req_t), sequences doors and travel on the slowref tick, and returns clr_g / clr_t to retire served requests.
- Drives the motor-direction and floor-indicator outputs.

Parameters:
DOOR_TICKS, 4, slowref ticks the door stays open per stop (>=1)
TRAVEL_TICKS, 8, slowref ticks to travel between floors (>=2)
IDLE_TICKS, 16, idle ticks at top before home return (used only with the optional feature, >=1)

Ports:
clk  in  1  system clock
resetb  in  1  synchronous active-low reset, sampled on posedge clk
slowref  in  1  one-clk-wide tick enable; all state advance is gated by it
req_g  in  1  ground-floor request flag (level)
req_t  in  1  top-floor request flag (level)
clr_g  out  1  clear for ground request; high throughout G_DOOR
clr_t  out  1  clear for top request; high throughout T_DOOR
mot_up  out  1  motor up; high in UP
mot_dn  out  1  motor down; high in DOWN
door_open  out  1  high in G_DOOR or T_DOOR
at_gnd  out  1  high in G_IDLE or G_DOOR
at_top  out  1  high in T_IDLE or T_DOOR
pos  out  $clog2(TRAVEL_TICKS+1)  car position, 0 = ground, TRAVEL_TICKS = top

Behaviour:
Clock, reset and tick
- Single clock clk. Reset is synchronous and active-low: resetb=0 at a posedge forces reset state regardless of slowref or the current state.
- Reset state: G_IDLE, pos=0, door counter=0, at_gnd=1, all other outputs 0.
- The state register, pos, and counters change only on posedge clk with slowref=1. With slowref=0, every register holds.

Outputs
- Moore outputs, registered alongside state (same edge). clr_x is therefore high on every tick cycle spent in X_DOOR.

States and transitions (evaluated on tick cycles)
- G_IDLE:
  - req_g=1 -> G_DOOR; load door counter with DOOR_TICKS-1. Own floor has priority, including when req_g and req_t are both high.
  - else req_t=1 -> UP.
  - else stay.
- G_DOOR:
  - counter>0 -> decrement.
  - counter==0 and req_t=1 -> UP.
  - counter==0 and req_t=0 -> G_IDLE.
  - req_g reasserting during G_DOOR is cleared by clr_g and does not extend the door.
- UP:
  - pos increments each tick.
  - When the increment makes pos==TRAVEL_TICKS -> T_DOOR; load counter.
- T_IDLE, T_DOOR, DOWN: mirror images of the above (pos decrements to 0, then G_DOOR).

Boundary conditions
- Requests are never reversal triggers. An opposite-floor request during UP/DOWN waits until the arrival door cycle completes.
- A same-floor request arriving while moving away from that floor is served on the next visit.
- pos never under- or overflows. Any other pos value in an at-floor state is illegal; the default branch forces G_IDLE, pos=0.
- Unused state encodings -> G_IDLE on the next tick.
- Reset mid-travel or with the door open returns to G_IDLE/pos=0 immediately. Pending requests are not cleared by reset of this block.

Optional Feature:
LIFT_HOME_RETURN_EN
- Defined:
  - An idle counter runs in T_IDLE, counting consecutive ticks with req_t=0 and req_g=0.
  - On reaching IDLE_TICKS -> DOWN.
  - Arrival from a home-return trip enters G_IDLE directly: no G_DOOR, no clr_g, unless req_g=1 on the arrival tick.
  - Any request resets the idle counter.
- Undefined:
  - No idle counter is built.
  - T_IDLE persists indefinitely without requests.

Decomposition:
- Package lift_pkg contains:
  - 3-bit state encoding constants G_IDLE, G_DOOR, UP, T_IDLE, T_DOOR, DOWN.
  - Default DOOR_TICKS, TRAVEL_TICKS, IDLE_TICKS.
- Sub-module tick_timer: loadable down-counter gated by slowref with a zero flag. Instantiated for the door timer and, with the macro, the idle timer.
- The pos counter stays inline.

Test Plan:
1. req_t=1 at G_IDLE, one tick -> UP. After 8 ticks pos=8 and T_DOOR with clr_t=1, door_open=1 for 4 ticks, then T_IDLE with at_top=1.
2. req_g=1 and req_t=1 together at G_IDLE -> G_DOOR, clr_g high 4 ticks, then UP. Arrive T_DOOR at tick 13 after the start.
3. req_g raised at pos=3 during UP -> ignored. T_DOOR runs its full 4 ticks, then DOWN, then G_DOOR with clr_g=1.
4. slowref held 0 for 50 clks with req_t=1 -> state, pos and all outputs unchanged.
5. resetb=0 for one clk at pos=5 in UP with slowref=0 -> next edge G_IDLE, pos=0, at_gnd=1, mot_up=0.
6. Macro defined, T_IDLE with no requests for 16 ticks -> DOWN. Arrival at G_IDLE with clr_g never asserted. Macro undefined -> stays in T_IDLE for 100 ticks.

Source files
------------

// File: rtl/lift_ctrl_pkg.sv
// lift_pkg: shared types and defaults for the two-floor lift controller.
// Holds the 3-bit state encoding, default timing values and the Moore
// output decode used by lift_ctrl.
package lift_pkg;

    typedef enum logic [2:0] {
        G_IDLE = 3'd0,
        G_DOOR = 3'd1,
        UP     = 3'd2,
        T_IDLE = 3'd3,
        T_DOOR = 3'd4,
        DOWN   = 3'd5
    } state_t;

    localparam int DEF_DOOR_TICKS   = 4;
    localparam int DEF_TRAVEL_TICKS = 8;
    localparam int DEF_IDLE_TICKS   = 16;

    // Moore output bundle, registered as one vector next to the state
    typedef struct packed {
        logic clr_g;
        logic clr_t;
        logic mot_up;
        logic mot_dn;
        logic door_open;
        logic at_gnd;
        logic at_top;
    } outs_t;

    // Output pattern for a given state; unused encodings drive everything low
    function automatic outs_t decode_outs(input state_t s);
        outs_t o;
        o = '0;
        case (s)
            G_IDLE: begin
                o.at_gnd = 1'b1;
            end
            G_DOOR: begin
                o.clr_g     = 1'b1;
                o.door_open = 1'b1;
                o.at_gnd    = 1'b1;
            end
            UP: begin
                o.mot_up = 1'b1;
            end
            T_IDLE: begin
                o.at_top = 1'b1;
            end
            T_DOOR: begin
                o.clr_t     = 1'b1;
                o.door_open = 1'b1;
                o.at_top    = 1'b1;
            end
            DOWN: begin
                o.mot_dn = 1'b1;
            end
            default: begin
                o = '0;
            end
        endcase
        return o;
    endfunction

endpackage

// File: rtl/lift_ctrl_tick_timer.sv
// tick_timer: loadable down-counter advanced only on slowref ticks.
// While load is high the counter is (re)loaded on each tick; otherwise it
// counts down to zero and sticks there. zero reports count == 0.
module tick_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         resetb,
    input  logic         slowref,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count;

    // Load or count down on each tick; never wraps below zero
    always_ff @(posedge clk) begin
        if (!resetb) begin
            count <= '0;
        end else if (slowref) begin
            if (load) begin
                count <= load_val;
            end else if (count != '0) begin
                count <= count - W'(1);
            end
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/lift_ctrl.sv
// lift_ctrl: two-floor (ground/top) lift movement controller.
// Consumes level request flags, sequences door and travel phases on the
// slowref tick, retires served requests via clr_g/clr_t and drives the
// motor and floor indicator outputs.
// Optional feature macro: LIFT_HOME_RETURN_EN -- after IDLE_TICKS request-free
// ticks at the top floor the car returns to ground without opening the door.
module lift_ctrl
    import lift_pkg::*;
#(
    parameter int DOOR_TICKS   = DEF_DOOR_TICKS,
    parameter int TRAVEL_TICKS = DEF_TRAVEL_TICKS,
    parameter int IDLE_TICKS   = DEF_IDLE_TICKS
) (
    input  logic                              clk,
    input  logic                              resetb,
    input  logic                              slowref,
    input  logic                              req_g,
    input  logic                              req_t,
    output logic                              clr_g,
    output logic                              clr_t,
    output logic                              mot_up,
    output logic                              mot_dn,
    output logic                              door_open,
    output logic                              at_gnd,
    output logic                              at_top,
    output logic [$clog2(TRAVEL_TICKS+1)-1:0] pos
);

    localparam int              PW        = $clog2(TRAVEL_TICKS + 1);
    localparam int              DW        = $clog2(DOOR_TICKS + 1);
    localparam logic [PW-1:0]   POS_TOP   = PW'(TRAVEL_TICKS);
    localparam logic [PW-1:0]   POS_LAST  = PW'(TRAVEL_TICKS - 1);
    localparam logic [PW-1:0]   POS_ONE   = PW'(1);
    localparam logic [DW-1:0]   DOOR_LOAD = DW'(DOOR_TICKS - 1);

    state_t state;
    outs_t  outs;
    logic   door_load;
    logic   door_zero;
    logic   idle_expired;
    logic   home_trip;

    // The door timer is held at its reload value outside the door states,
    // so it already holds DOOR_TICKS-1 on the tick that opens the door.
    assign door_load = (state != G_DOOR) && (state != T_DOOR);

    tick_timer #(
        .W (DW)
    ) u_door_timer (
        .clk      (clk),
        .resetb   (resetb),
        .slowref  (slowref),
        .load     (door_load),
        .load_val (DOOR_LOAD),
        .zero     (door_zero)
    );

`ifdef LIFT_HOME_RETURN_EN
    localparam int            IW        = $clog2(IDLE_TICKS + 1);
    localparam logic [IW-1:0] IDLE_LOAD = IW'(IDLE_TICKS - 1);

    logic idle_run;
    logic idle_zero;

    // Idle ticks are only those spent at the top with no request pending;
    // anything else (including any request) reloads the idle timer.
    assign idle_run     = (state == T_IDLE) && !req_g && !req_t;
    assign idle_expired = idle_run && idle_zero;

    tick_timer #(
        .W (IW)
    ) u_idle_timer (
        .clk      (clk),
        .resetb   (resetb),
        .slowref  (slowref),
        .load     (!idle_run),
        .load_val (IDLE_LOAD),
        .zero     (idle_zero)
    );

    // Remember that the current descent was started by the idle timeout
    always_ff @(posedge clk) begin
        if (!resetb) begin
            home_trip <= 1'b0;
        end else if (slowref) begin
            if (state == T_IDLE) begin
                home_trip <= idle_expired;
            end else if (state != DOWN || pos == POS_ONE) begin
                home_trip <= 1'b0;
            end
        end
    end
`else
    assign idle_expired = 1'b0;
    assign home_trip    = 1'b0;
`endif

    // State, position and registered Moore outputs advance together on each tick
    always_ff @(posedge clk) begin
        if (!resetb) begin
            state <= G_IDLE;
            pos   <= '0;
            outs  <= decode_outs(G_IDLE);
        end else if (slowref) begin
            case (state)
                G_IDLE: begin
                    if (pos != '0) begin
                        state <= G_IDLE;
                        pos   <= '0;
                        outs  <= decode_outs(G_IDLE);
                    end else if (req_g) begin
                        // own floor wins even when both requests are up
                        state <= G_DOOR;
                        outs  <= decode_outs(G_DOOR);
                    end else if (req_t) begin
                        state <= UP;
                        outs  <= decode_outs(UP);
                    end
                end

                G_DOOR: begin
                    if (pos != '0) begin
                        state <= G_IDLE;
                        pos   <= '0;
                        outs  <= decode_outs(G_IDLE);
                    end else if (door_zero) begin
                        if (req_t) begin
                            state <= UP;
                            outs  <= decode_outs(UP);
                        end else begin
                            state <= G_IDLE;
                            outs  <= decode_outs(G_IDLE);
                        end
                    end
                end

                UP: begin
                    if (pos >= POS_TOP) begin
                        state <= G_IDLE;
                        pos   <= '0;
                        outs  <= decode_outs(G_IDLE);
                    end else begin
                        pos <= pos + POS_ONE;
                        if (pos == POS_LAST) begin
                            state <= T_DOOR;
                            outs  <= decode_outs(T_DOOR);
                        end
                    end
                end

                T_IDLE: begin
                    if (pos != POS_TOP) begin
                        state <= G_IDLE;
                        pos   <= '0;
                        outs  <= decode_outs(G_IDLE);
                    end else if (req_t) begin
                        state <= T_DOOR;
                        outs  <= decode_outs(T_DOOR);
                    end else if (req_g || idle_expired) begin
                        state <= DOWN;
                        outs  <= decode_outs(DOWN);
                    end
                end

                T_DOOR: begin
                    if (pos != POS_TOP) begin
                        state <= G_IDLE;
                        pos   <= '0;
                        outs  <= decode_outs(G_IDLE);
                    end else if (door_zero) begin
                        if (req_g) begin
                            state <= DOWN;
                            outs  <= decode_outs(DOWN);
                        end else begin
                            state <= T_IDLE;
                            outs  <= decode_outs(T_IDLE);
                        end
                    end
                end

                DOWN: begin
                    if (pos == '0 || pos > POS_TOP) begin
                        state <= G_IDLE;
                        pos   <= '0;
                        outs  <= decode_outs(G_IDLE);
                    end else begin
                        pos <= pos - POS_ONE;
                        if (pos == POS_ONE) begin
                            // a home-return arrival skips the door unless
                            // someone is actually waiting at ground
                            if (home_trip && !req_g) begin
                                state <= G_IDLE;
                                outs  <= decode_outs(G_IDLE);
                            end else begin
                                state <= G_DOOR;
                                outs  <= decode_outs(G_DOOR);
                            end
                        end
                    end
                end

                default: begin
                    state <= G_IDLE;
                    pos   <= '0;
                    outs  <= decode_outs(G_IDLE);
                end
            endcase
        end
    end

    assign clr_g     = outs.clr_g;
    assign clr_t     = outs.clr_t;
    assign mot_up    = outs.mot_up;
    assign mot_dn    = outs.mot_dn;
    assign door_open = outs.door_open;
    assign at_gnd    = outs.at_gnd;
    assign at_top    = outs.at_top;

endmodule

// File: tb/tb_lift_ctrl.sv
// tb_lift_ctrl: directed and randomized bench for lift_ctrl.
// The reference model describes the car as position / travel direction /
// remaining door ticks / idle count and derives the expected outputs from them.
module tb_lift_ctrl;

    localparam int DOOR   = 4;
    localparam int TRAVEL = 8;
    localparam int IDLE   = 16;
    localparam int PW     = $clog2(TRAVEL + 1);

    logic          clk     = 1'b0;
    logic          resetb  = 1'b0;
    logic          slowref = 1'b0;
    logic          req_g   = 1'b0;
    logic          req_t   = 1'b0;
    logic          clr_g, clr_t, mot_up, mot_dn, door_open, at_gnd, at_top;
    logic [PW-1:0] pos;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int m_pos;
    int m_dir;
    int m_door;
    int m_idle;
    bit m_home;

    lift_ctrl #(
        .DOOR_TICKS   (DOOR),
        .TRAVEL_TICKS (TRAVEL),
        .IDLE_TICKS   (IDLE)
    ) dut (
        .clk       (clk),
        .resetb    (resetb),
        .slowref   (slowref),
        .req_g     (req_g),
        .req_t     (req_t),
        .clr_g     (clr_g),
        .clr_t     (clr_t),
        .mot_up    (mot_up),
        .mot_dn    (mot_dn),
        .door_open (door_open),
        .at_gnd    (at_gnd),
        .at_top    (at_top),
        .pos       (pos)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not complete, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic model_reset();
        m_pos  = 0;
        m_dir  = 0;
        m_door = 0;
        m_idle = 0;
        m_home = 1'b0;
    endtask

    task automatic model_step(input logic rg, input logic rt);
        if (m_door > 0) begin
            m_idle = 0;
            m_door = m_door - 1;
            if (m_door == 0) begin
                if (m_pos == 0 && rt) m_dir = 1;
                else if (m_pos == TRAVEL && rg) m_dir = -1;
            end
        end else if (m_dir == 1) begin
            m_idle = 0;
            m_pos  = m_pos + 1;
            if (m_pos == TRAVEL) begin
                m_dir  = 0;
                m_door = DOOR;
            end
        end else if (m_dir == -1) begin
            m_idle = 0;
            m_pos  = m_pos - 1;
            if (m_pos == 0) begin
                m_dir = 0;
                if (!(m_home && !rg)) m_door = DOOR;
                m_home = 1'b0;
            end
        end else if (m_pos == 0) begin
            m_idle = 0;
            if (rg) m_door = DOOR;
            else if (rt) m_dir = 1;
        end else begin
            if (rt) begin
                m_idle = 0;
                m_door = DOOR;
            end else if (rg) begin
                m_idle = 0;
                m_dir  = -1;
            end else begin
`ifdef LIFT_HOME_RETURN_EN
                m_idle = m_idle + 1;
                if (m_idle == IDLE) begin
                    m_idle = 0;
                    m_dir  = -1;
                    m_home = 1'b1;
                end
`endif
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        check({tag, " pos"},       32'(pos),       32'(m_pos));
        check({tag, " door_open"}, 32'(door_open), 32'(m_door > 0));
        check({tag, " clr_g"},     32'(clr_g),     32'(m_door > 0 && m_pos == 0));
        check({tag, " clr_t"},     32'(clr_t),     32'(m_door > 0 && m_pos == TRAVEL));
        check({tag, " mot_up"},    32'(mot_up),    32'(m_dir == 1));
        check({tag, " mot_dn"},    32'(mot_dn),    32'(m_dir == -1));
        check({tag, " at_gnd"},    32'(at_gnd),    32'(m_dir == 0 && m_pos == 0));
        check({tag, " at_top"},    32'(at_top),    32'(m_dir == 0 && m_pos == TRAVEL));
    endtask

    // one slowref tick; request latches upstream drop a flag once its clear is seen
    task automatic do_tick();
        slowref = 1'b1;
        @(posedge clk);
        model_step(req_g, req_t);
        @(negedge clk);
        slowref = 1'b0;
        if (m_door > 0 && m_pos == 0)      req_g = 1'b0;
        if (m_door > 0 && m_pos == TRAVEL) req_t = 1'b0;
    endtask

    task automatic run_ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            do_tick();
            check_all(tag);
        end
    endtask

    task automatic do_reset();
        resetb = 1'b0;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        resetb = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();
        check_all("reset");
        check("reset at_gnd", 32'(at_gnd), 32'd1);

        // top request from ground idle: travel, door at top, then top idle
        req_t = 1'b1;
        do_tick();
        check_all("tp1 start");
        check("tp1 mot_up", 32'(mot_up), 32'd1);
        run_ticks(7, "tp1 travel");
        do_tick();
        check_all("tp1 arrive");
        check("tp1 pos top", 32'(pos), 32'(TRAVEL));
        check("tp1 clr_t", 32'(clr_t), 32'd1);
        for (int i = 0; i < 3; i++) begin
            do_tick();
            check("tp1 door held", 32'(door_open), 32'd1);
        end
        do_tick();
        check_all("tp1 idle");
        check("tp1 at_top", 32'(at_top), 32'd1);
        check("tp1 door closed", 32'(door_open), 32'd0);

        // back to ground
        req_g = 1'b1;
        run_ticks(13, "return");
        check("return at_gnd", 32'(at_gnd), 32'd1);

        // both requests at ground idle: own floor first, then up
        req_g = 1'b1;
        req_t = 1'b1;
        do_tick();
        check_all("tp2 door");
        check("tp2 clr_g", 32'(clr_g), 32'd1);
        run_ticks(10, "tp2 seq");
        do_tick();
        check("tp2 still moving", 32'(mot_up), 32'd1);
        check("tp2 pos 7", 32'(pos), 32'd7);
        do_tick();
        check_all("tp2 arrive");
        check("tp2 at_top tick13", 32'(at_top), 32'd1);
        check("tp2 clr_t tick13", 32'(clr_t), 32'd1);
        run_ticks(4, "tp2 door");

        // ground request raised mid-ascent is served only after the top door
        req_g = 1'b1;
        run_ticks(13, "tp3 pre");
        req_t = 1'b1;
        run_ticks(4, "tp3 up");
        check("tp3 pos 3", 32'(pos), 32'd3);
        req_g = 1'b1;
        run_ticks(5, "tp3 continue");
        check("tp3 no reversal", 32'(at_top), 32'd1);
        for (int i = 0; i < 3; i++) begin
            do_tick();
            check_all("tp3 tdoor");
            check("tp3 door full", 32'(door_open), 32'd1);
        end
        do_tick();
        check("tp3 down", 32'(mot_dn), 32'd1);
        run_ticks(7, "tp3 descend");
        do_tick();
        check_all("tp3 gdoor");
        check("tp3 clr_g", 32'(clr_g), 32'd1);
        run_ticks(4, "tp3 close");

        // no tick for 50 clocks: nothing moves despite a pending request
        req_t = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i % 10 == 9) check_all("tp4 hold");
        end
        check("tp4 mot_up", 32'(mot_up), 32'd0);
        check("tp4 at_gnd", 32'(at_gnd), 32'd1);

        // reset in mid travel
        run_ticks(6, "tp5 travel");
        check("tp5 pos 5", 32'(pos), 32'd5);
        do_reset();
        check_all("tp5 reset");
        check("tp5 pos 0", 32'(pos), 32'd0);
        check("tp5 at_gnd", 32'(at_gnd), 32'd1);
        check("tp5 mot_up", 32'(mot_up), 32'd0);

        // reach top idle with no further requests (req_t still pending)
        run_ticks(13, "tp6 reach");
        check("tp6 at_top", 32'(at_top), 32'd1);
        check("tp6 door", 32'(door_open), 32'd0);
`ifdef LIFT_HOME_RETURN_EN
        for (int i = 0; i < IDLE - 1; i++) begin
            do_tick();
            check_all("tp6 idle");
        end
        do_tick();
        check_all("tp6 home start");
        check("tp6 mot_dn", 32'(mot_dn), 32'd1);
        for (int i = 0; i < TRAVEL; i++) begin
            do_tick();
            check_all("tp6 home");
            check("tp6 no clr_g", 32'(clr_g), 32'd0);
        end
        check("tp6 home at_gnd", 32'(at_gnd), 32'd1);
        check("tp6 home door", 32'(door_open), 32'd0);
`else
        for (int i = 0; i < 100; i++) begin
            do_tick();
            check_all("tp6 stay");
            check("tp6 stay at_top", 32'(at_top), 32'd1);
        end
`endif

        // randomized requests, tick spacing and occasional reset
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) req_g = 1'b1;
            if ($urandom_range(0, 5) == 0) req_t = 1'b1;
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
                check_all("rnd reset");
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_tick();
            check_all("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
